// File: rtl/prbs_pack.sv
// Shared PRBS definitions used by the TX generator and the checker.
package prbs_pack;
    localparam int Nprbs = 32;
    localparam int Nti   = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} prbs_tx_state_t;

    localparam logic [31:0] PRBS7  = 32'h0000_0060;
    localparam logic [31:0] PRBS15 = 32'h0000_6000;
    localparam logic [31:0] PRBS31 = 32'h4800_0000;
endpackage

// File: rtl/prbs_parallel_step.sv
// Combinational unroll of n_channels Fibonacci LFSR steps; word bit 0 is the first step.
module prbs_parallel_step #(
    parameter int n_prbs     = 32,
    parameter int n_channels = 16
) (
    input  logic [n_prbs-1:0]     state_i,
    input  logic [n_prbs-1:0]     eqn_i,
    output logic [n_prbs-1:0]     state_o,
    output logic [n_channels-1:0] word_o
);
    logic [n_prbs-1:0] s;
    logic              b;

    always_comb begin
        s      = state_i;
        b      = 1'b0;
        word_o = '0;
        for (int i = 0; i < n_channels; i++) begin
            b         = ^(s & eqn_i);
            word_o[i] = b;
            s         = {s[n_prbs-2:0], b};
        end
        state_o = s;
    end
endmodule

// File: rtl/prbs_tx_generator.sv
// Parallel PRBS transmitter: one n_channels-bit word per enabled RUN cycle,
// with burst/continuous modes, per-lane inversion and single-bit error injection.
module prbs_tx_generator
    import prbs_pack::*;
#(
    parameter int n_prbs     = Nprbs,
    parameter int n_channels = Nti,
    parameter int n_cnt      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cke,
    input  logic [n_prbs-1:0]             eqn,
    input  logic [n_prbs-1:0]             init_val,
    input  logic [n_channels-1:0]         inv_chicken,
    input  logic                          start,
    input  logic                          stop,
    input  logic [n_cnt-1:0]              burst_len,
    input  logic                          err_inj_req,
    input  logic [$clog2(n_channels)-1:0] err_inj_lane,
    output logic [n_channels-1:0]         tx_bits,
    output logic                          tx_valid,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   err_inj_count
);
    localparam int LW = $clog2(n_channels);

    prbs_tx_state_t        state_q, state_d;
    logic [n_prbs-1:0]     lfsr_q, lfsr_d;
    logic [n_cnt-1:0]      word_cnt_q, word_cnt_d;
    logic [n_channels-1:0] tx_bits_q, tx_bits_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  done_q, done_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [LW-1:0]         lane_q, lane_d;

    logic [n_prbs-1:0]     step_state;
    logic [n_channels-1:0] step_word;
    logic                  inj_pend;
    logic [LW-1:0]         inj_lane;
    logic                  inj_ok;
    logic [n_channels-1:0] inj_mask;

    prbs_parallel_step #(
        .n_prbs     (n_prbs),
        .n_channels (n_channels)
    ) u_step (
        .state_i (lfsr_q),
        .eqn_i   (eqn),
        .state_o (step_state),
        .word_o  (step_word)
    );

    // A request arriving on the same edge as a word still lands on that word.
    assign inj_pend = pend_q | err_inj_req;
    assign inj_lane = err_inj_req ? err_inj_lane : lane_q;
    assign inj_ok   = 32'(inj_lane) < n_channels;

    always_comb begin
        inj_mask = '0;
        if (inj_pend && inj_ok)
            inj_mask[inj_lane] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        word_cnt_d = word_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_valid_d = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        pend_d     = inj_pend;
        lane_d     = inj_lane;
        if (cke) begin
            case (state_q)
                IDLE: begin
                    tx_bits_d = '0;
                    if (start && !stop) begin
                        state_d    = RUN;
                        lfsr_d     = (init_val == '0) ? '1 : init_val;
                        word_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d   = IDLE;
                        tx_bits_d = '0;
                    end else begin
                        lfsr_d     = step_state;
                        tx_bits_d  = step_word ^ inv_chicken ^ inj_mask;
                        tx_valid_d = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (inj_pend) begin
                            pend_d = 1'b0;
                            if (inj_ok && cnt_q != 16'hFFFF)
                                cnt_d = cnt_q + 16'd1;
                        end
                        if (burst_len != '0 && word_cnt_q == burst_len - 1'b1)
                            state_d = DONE;
                    end
                end
                DONE: begin
                    state_d   = IDLE;
                    tx_bits_d = '0;
                    done_d    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= '1;
            word_cnt_q <= '0;
            tx_bits_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            lane_q     <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            word_cnt_q <= word_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            lane_q     <= lane_d;
        end
    end

    assign tx_bits       = tx_bits_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign err_inj_count = cnt_q;
endmodule

// File: tb/tb_prbs_tx_generator.sv
// Directed bench for prbs_tx_generator: bit-recurrence reference model plus literal pins.
module tb_prbs_tx_generator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic [31:0] eqn = 32'h60;
    logic [31:0] init_val = 32'h1;
    logic [15:0] inv_chicken = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] burst_len = '0;
    logic        err_inj_req = 1'b0;
    logic [3:0]  err_inj_lane = '0;
    logic [15:0] tx_bits;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic [15:0] err_inj_count;

    int errors = 0;
    int checks = 0;

    prbs_tx_generator dut (
        .clk           (clk),
        .rst           (rst),
        .cke           (cke),
        .eqn           (eqn),
        .init_val      (init_val),
        .inv_chicken   (inv_chicken),
        .start         (start),
        .stop          (stop),
        .burst_len     (burst_len),
        .err_inj_req   (err_inj_req),
        .err_inj_lane  (err_inj_lane),
        .tx_bits       (tx_bits),
        .tx_valid      (tx_valid),
        .busy          (busy),
        .done          (done),
        .err_inj_count (err_inj_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the PRBS is the recurrence x[n] = XOR of x[n-1-j] over taps j,
    // with the seed supplying the 32 bits before the run (seed bit 0 is the newest).
    bit          mq[$];
    int          m_mode = 0;  // 0 idle, 1 run, 2 done
    logic        m_valid = 0;
    logic [15:0] m_bits = 0;
    logic        m_done = 0;
    logic [15:0] m_cnt = 0;
    logic        m_pend = 0;
    logic [3:0]  m_lane = 0;
    logic [31:0] m_wcnt = 0;

    initial begin
        logic [31:0] seed;
        logic [15:0] w;
        bit          nb;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_valid = 0; m_bits = 0; m_done = 0;
                m_cnt = 0; m_pend = 0; m_lane = 0; m_wcnt = 0;
            end else begin
                if (err_inj_req) begin
                    m_pend = 1;
                    m_lane = err_inj_lane;
                end
                m_valid = 0;
                m_done  = 0;
                if (cke) begin
                    if (m_mode == 0) begin
                        m_bits = 0;
                        if (start && !stop) begin
                            seed = (init_val == 0) ? 32'hFFFF_FFFF : init_val;
                            mq.delete();
                            for (int m = 31; m >= 0; m--) mq.push_back(seed[m]);
                            m_wcnt = 0;
                            m_mode = 1;
                        end
                    end else if (m_mode == 1) begin
                        if (stop) begin
                            m_mode = 0;
                            m_bits = 0;
                        end else begin
                            w = 0;
                            for (int i = 0; i < 16; i++) begin
                                nb = 0;
                                for (int j = 0; j < 32; j++)
                                    if (eqn[j]) nb ^= mq[mq.size() - 1 - j];
                                mq.push_back(nb);
                                void'(mq.pop_front());
                                w[i] = nb;
                            end
                            w ^= inv_chicken;
                            if (m_pend) begin
                                if (int'(m_lane) < 16) begin
                                    w[m_lane] = ~w[m_lane];
                                    if (m_cnt != 16'hFFFF) m_cnt++;
                                end
                                m_pend = 0;
                            end
                            m_bits  = w;
                            m_valid = 1;
                            if (burst_len != 0 && m_wcnt == burst_len - 1) m_mode = 2;
                            m_wcnt++;
                        end
                    end else begin
                        m_mode = 0;
                        m_bits = 0;
                        m_done = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        check("tx_valid", {31'b0, tx_valid}, {31'b0, m_valid});
        check("tx_bits", {16'b0, tx_bits}, {16'b0, m_bits});
        check("busy", {31'b0, busy}, {31'b0, (m_mode == 1)});
        check("done", {31'b0, done}, {31'b0, m_done});
        check("err_inj_count", {16'b0, err_inj_count}, {16'b0, m_cnt});
    end

    logic [15:0] words[$];
    logic [15:0] gold[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && tx_valid) words.push_back(tx_bits);
        if (!rst && done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int b;
        b = 0;
        while (words.size() < n && b < budget) begin
            tick(1);
            b++;
        end
        if (words.size() < n) check("wait_words_timeout", words.size(), n);
    endtask

    task automatic chk_word(input string name, input int idx, input logic [15:0] exp);
        if (words.size() > idx) check(name, {16'b0, words[idx]}, {16'b0, exp});
        else check({name, "_missing"}, words.size(), idx + 1);
    endtask

    initial begin
        int          ndiff;
        logic [15:0] d0, d1;

        // Reset state
        tick(3);
        check("rst_tx_bits", {16'b0, tx_bits}, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_count", {16'b0, err_inj_count}, 0);
        rst = 1'b0;
        tick(2);

        // PRBS7 continuous: first word and 127-word period
        words.delete();
        pulse_start();
        wait_words(130, 300);
        chk_word("prbs7_word0", 0, 16'h2860);
        chk_word("prbs7_word127", 127, 16'h2860);
        pulse_stop();
        tick(2);
        check("stop_valid", {31'b0, tx_valid}, 0);
        gold = words;

        // Burst of 5
        burst_len = 5;
        words.delete();
        done_cnt = 0;
        pulse_start();
        tick(12);
        check("burst_words", words.size(), 5);
        check("burst_done", done_cnt, 1);
        check("burst_busy", {31'b0, busy}, 0);
        check("burst_bits", {16'b0, tx_bits}, 0);

        // Zero seed falls back to all-ones
        burst_len = 3;
        init_val  = 0;
        words.delete();
        pulse_start();
        tick(8);
        chk_word("zero_seed_word0", 0, 16'h3040);

        // Inversion
        init_val    = 1;
        inv_chicken = 16'hFFFF;
        words.delete();
        pulse_start();
        tick(8);
        chk_word("inv_word0", 0, 16'hD79F);
        inv_chicken = 0;

        // Error injection, merged requests under cke=0, 10-cycle freeze
        burst_len = 0;
        words.delete();
        pulse_start();
        tick(3);
        err_inj_req = 1; err_inj_lane = 3;
        tick(1);
        err_inj_req = 0;
        tick(3);
        check("inj_count1", {16'b0, err_inj_count}, 1);
        cke = 0;
        err_inj_req = 1; err_inj_lane = 1;
        tick(1);
        err_inj_lane = 2;
        tick(1);
        err_inj_req = 0;
        tick(8);
        cke = 1;
        tick(4);
        pulse_stop();
        tick(2);
        check("inj_count2", {16'b0, err_inj_count}, 2);
        ndiff = 0; d0 = 0; d1 = 0;
        for (int k = 0; k < words.size() && k < gold.size(); k++) begin
            if (words[k] != gold[k]) begin
                if (ndiff == 0) d0 = words[k] ^ gold[k];
                else if (ndiff == 1) d1 = words[k] ^ gold[k];
                ndiff++;
            end
        end
        check("inj_ndiff", ndiff, 2);
        check("inj_diff0", {16'b0, d0}, 32'h0008);
        check("inj_diff1", {16'b0, d1}, 32'h0004);

        // start+stop together in IDLE
        start = 1; stop = 1;
        tick(1);
        start = 0; stop = 0;
        tick(1);
        check("ss_busy", {31'b0, busy}, 0);
        check("ss_valid", {31'b0, tx_valid}, 0);

        // Stop mid-burst: no done
        burst_len = 10;
        done_cnt  = 0;
        pulse_start();
        tick(3);
        pulse_stop();
        check("midstop_valid", {31'b0, tx_valid}, 0);
        tick(12);
        check("midstop_done", done_cnt, 0);

        // Async reset mid-run discards a pending injection
        burst_len = 0;
        pulse_start();
        tick(3);
        cke = 0;
        err_inj_req = 1; err_inj_lane = 5;
        tick(1);
        err_inj_req = 0;
        #2 rst = 1;
        #1;
        check("arst_bits", {16'b0, tx_bits}, 0);
        check("arst_valid", {31'b0, tx_valid}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_count", {16'b0, err_inj_count}, 0);
        tick(2);
        rst = 0;
        cke = 1;
        tick(1);
        pulse_start();
        tick(6);
        check("post_rst_count", {16'b0, err_inj_count}, 0);
        pulse_stop();
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
